// File: rtl/key_debounce_pkg.sv
// Board constants and helpers shared by the key debouncer.
// 12 MHz clock, keys idle high (pressed = 0), 20 ms settle time.
package key_debounce_pkg;

  localparam int CLK_FREQ_HZ       = 12_000_000;
  localparam bit KEY_IDLE_LEVEL    = 1'b1;
  localparam int DEBOUNCE_MS       = 20;
  localparam int DB_CYCLES_DEFAULT = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;

  // Raw pin level of a released key.
  function automatic logic idle_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel.
// Contains a two-flop synchroniser, a stability counter, the accepted level and the edge strobes.
module debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW = KEY_IDLE_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  if (DB_CYCLES < 2) begin : g_param_check
    $error("debounce_ch: DB_CYCLES must be at least 2");
  end

  localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic             IDLE     = idle_level(ACTIVE_LOW);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] count_reg;
  logic             level_reg;
  logic             press_reg;
  logic             release_reg;
  logic             sync_n;

  // 1 = pressed, whatever the board polarity.
  assign sync_n = ACTIVE_LOW ? ~sync2_reg : sync2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg   <= IDLE;
      sync2_reg   <= IDLE;
      count_reg   <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      sync1_reg   <= key_in;
      sync2_reg   <= sync1_reg;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      if (sync_n == level_reg) begin
        count_reg <= '0;
      end else if (count_reg == CNT_LAST) begin
        // Strobe comes out together with the new level.
        level_reg   <= sync_n;
        count_reg   <= '0;
        press_reg   <= sync_n;
        release_reg <= ~sync_n;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign key_level   = level_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;

endmodule

// File: rtl/key_debounce.sv
// Debounces KEY_WIDTH raw board keys into clean levels plus press/release strobes.
// key_level[0] drives mux21 a, [1] drives b, [2] drives s.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int KEY_WIDTH  = 3,
  parameter int DB_CYCLES  = DB_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW = KEY_IDLE_LEVEL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic [KEY_WIDTH-1:0] key_level,
  output logic [KEY_WIDTH-1:0] key_press,
  output logic [KEY_WIDTH-1:0] key_release
);

  for (genvar gi = 0; gi < KEY_WIDTH; gi++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES  (DB_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in[gi]),
      .key_level   (key_level[gi]),
      .key_press   (key_press[gi]),
      .key_release (key_release[gi])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES=8: a window model is checked every cycle,
// and hand-computed literals pin the key instants.
module tb_key_debounce;

  localparam int KW = 3;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [KW-1:0] key_in = 3'b111;
  logic [KW-1:0] key_level;
  logic [KW-1:0] key_press;
  logic [KW-1:0] key_release;

  always #5 clk = ~clk;

  key_debounce #(
    .KEY_WIDTH  (KW),
    .DB_CYCLES  (DB),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  // Model: the pressed samples taken at each edge are kept. The synchroniser delay is two edges.
  // A level flips to v once the last DB delayed samples all equal v.
  logic [KW-1:0] hist[$];
  logic [KW-1:0] m_level   = '0;
  logic [KW-1:0] m_press   = '0;
  logic [KW-1:0] m_release = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      for (int i = 0; i < DB + 2; i++) hist.push_back('0);
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
    end else begin
      logic [KW-1:0] s;
      logic          v;
      bit            stable;
      hist.push_back(~key_in);
      if (hist.size() > DB + 2) void'(hist.pop_front());
      m_press   = '0;
      m_release = '0;
      for (int c = 0; c < KW; c++) begin
        s      = hist[hist.size() - 3];
        v      = s[c];
        stable = 1'b1;
        for (int k = 0; k < DB; k++) begin
          s = hist[hist.size() - 3 - k];
          if (s[c] != v) stable = 1'b0;
        end
        if (stable && v != m_level[c]) begin
          m_level[c] = v;
          if (v) m_press[c] = 1'b1;
          else   m_release[c] = 1'b1;
        end
      end
    end
  end

  // Literal expectations posted by the stimulus, consumed by the compare process.
  int          lit_seq  = 0;
  int          lit_seen = 0;
  string       lit_name = "";
  logic [8:0]  lit_exp  = '0;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  always @(negedge clk) begin
    cyc++;
    chk_cnt++;
    if ({key_level, key_press, key_release} === {m_level, m_press, m_release})
      pass_cnt++;
    else
      $display("FAIL model cyc=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
               cyc, key_level, key_press, key_release, m_level, m_press, m_release);
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      chk_cnt++;
      if ({key_level, key_press, key_release} === lit_exp)
        pass_cnt++;
      else
        $display("FAIL %s cyc=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
                 lit_name, cyc, key_level, key_press, key_release,
                 lit_exp[8:6], lit_exp[5:3], lit_exp[2:0]);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_lit(input string name, input logic [2:0] lvl,
                            input logic [2:0] prs, input logic [2:0] rel);
    lit_name = name;
    lit_exp  = {lvl, prs, rel};
    lit_seq++;
    $display("txn %-14s expect lvl=%b prs=%b rel=%b", name, lvl, prs, rel);
  endtask

  initial begin
    // 1: reset and idle
    tick(3);
    expect_lit("reset", 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    tick(50);
    expect_lit("idle50", 3'b000, 3'b000, 3'b000);

    // 2: key0 pressed and held
    key_in = 3'b110;
    tick(9);
    expect_lit("k0_edge9", 3'b000, 3'b000, 3'b000);
    tick(1);
    expect_lit("k0_press", 3'b001, 3'b001, 3'b000);
    tick(1);
    expect_lit("k0_held", 3'b001, 3'b000, 3'b000);

    // 3: key1 bounces with period 3, then settles pressed
    for (int t = 0; t < 10; t++) begin
      key_in[1] = ~key_in[1];
      tick(3);
    end
    expect_lit("k1_bounce", 3'b001, 3'b000, 3'b000);
    key_in[1] = 1'b0;
    tick(9);
    expect_lit("k1_edge9", 3'b001, 3'b000, 3'b000);
    tick(1);
    expect_lit("k1_press", 3'b011, 3'b010, 3'b000);
    tick(1);
    expect_lit("k1_held", 3'b011, 3'b000, 3'b000);

    // 4: key2 glitch of 7 cycles is rejected, 9 cycles is accepted
    key_in[2] = 1'b0;
    tick(7);
    key_in[2] = 1'b1;
    tick(12);
    expect_lit("k2_glitch7", 3'b011, 3'b000, 3'b000);
    key_in[2] = 1'b0;
    tick(9);
    key_in[2] = 1'b1;
    tick(1);
    expect_lit("k2_press9", 3'b111, 3'b100, 3'b000);
    tick(8);
    expect_lit("k2_hold", 3'b111, 3'b000, 3'b000);
    tick(1);
    expect_lit("k2_release", 3'b011, 3'b000, 3'b100);
    tick(1);
    expect_lit("k2_after", 3'b011, 3'b000, 3'b000);

    // 5: key0 released
    key_in[0] = 1'b1;
    tick(9);
    expect_lit("k0_rel_edge9", 3'b011, 3'b000, 3'b000);
    tick(1);
    expect_lit("k0_release", 3'b010, 3'b000, 3'b001);
    tick(1);
    expect_lit("k0_released", 3'b010, 3'b000, 3'b000);

    // 6: all keys pressed together, reset pulsed mid-count
    key_in = 3'b111;
    tick(12);
    expect_lit("all_idle", 3'b000, 3'b000, 3'b000);
    key_in = 3'b000;
    tick(5);
    rst = 1'b1;
    expect_lit("mid_reset", 3'b000, 3'b000, 3'b000);
    tick(1);
    rst = 1'b0;
    tick(9);
    expect_lit("all_edge9", 3'b000, 3'b000, 3'b000);
    tick(1);
    expect_lit("all_press", 3'b111, 3'b111, 3'b000);
    tick(1);
    expect_lit("all_held", 3'b111, 3'b000, 3'b000);

    tick(2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
